// File: rtl/shim_hw_sts_evt_fifo.sv
// Status-flag event queue: rising edges of the synchronized status flags become
// 8-bit event words {code, channel} in a first-word-fall-through FIFO, with first-fault and loss tracking.
module shim_hw_sts_evt_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [1:0]                   sys_flags,
  input  logic [103:0]                 ch_flags,
  input  logic                         clr,
  input  logic                         evt_ready,
  output logic                         evt_valid,
  output logic [7:0]                   evt_data,
  output logic [$clog2(FIFO_DEPTH):0]  evt_count,
  output logic [7:0]                   first_fault,
  output logic                         first_fault_valid,
  output logic                         irq,
  output logic                         evt_overflow,
  output logic [7:0]                   lost_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NF = 106;
  localparam logic [NF-1:0] NF_ONE = {{(NF-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [NF-1:0] w_flags;
  logic [NF-1:0] w_edge;
  logic [NF-1:0] w_sel;
  logic [NF-1:0] w_lose;
  logic [NF-1:0] w_pend_nxt;
  logic [6:0]    w_idx;
  logic [6:0]    w_j;
  logic [6:0]    w_nlost;
  logic [8:0]    w_lost_sum;
  logic [7:0]    w_lost_nxt;
  logic [7:0]    w_word;
  logic          w_any;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  logic [NF-1:0] r_prev;
  logic [NF-1:0] r_pending;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [7:0]    r_ff;
  logic          r_ffv;
  logic          r_irq;
  logic          r_ovf;
  logic [7:0]    r_lost;

  assign w_flags = {ch_flags, sys_flags};
  assign w_edge  = w_flags & ~r_prev;
  assign w_any   = |r_pending;
  assign w_full  = (r_count == DEPTH_W);
  assign w_pop   = (r_count != '0) & evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push  = w_any & (~w_full | w_pop);

  // Lowest-index pending flag wins the scanner
  always_comb begin
    w_idx = 7'd0;
    for (int i = NF - 1; i >= 0; i--) begin
      w_idx = r_pending[i] ? 7'(i) : w_idx;
    end
  end

  // Flag index to event word: sys flags map to codes 1..2, channel groups to codes 3..15
  always_comb begin
    w_j = w_idx - 7'd2;
    if (w_idx < 7'd2) begin
      w_word = {({4'd0, w_idx[0]} + 5'd1), 3'd0};
    end else begin
      w_word = {({1'b0, w_j[6:3]} + 5'd3), w_j[2:0]};
    end
  end

  // Clearing the scanned bit loses to a new edge on the same bit (set wins, no loss)
  always_comb begin
    w_sel      = w_push ? (NF_ONE << w_idx) : '0;
    w_pend_nxt = (r_pending & ~w_sel) | w_edge;
    w_lose     = r_pending & ~w_sel & w_edge;
    w_nlost    = 7'd0;
    for (int i = 0; i < NF; i++) begin
      w_nlost = w_nlost + 7'(w_lose[i]);
    end
    w_lost_sum = {1'b0, r_lost} + {2'b00, w_nlost};
    w_lost_nxt = (w_lost_sum > 9'd255) ? 8'hFF : w_lost_sum[7:0];
  end

  // FIFO storage; contents need no reset because the output is gated by occupancy
  always_ff @(posedge aclk) begin
    if (!areset && !clr && w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // Control state: edge history, pending bitmap, FIFO pointers and fault bookkeeping
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ff      <= 8'd0;
      r_ffv     <= 1'b0;
      r_irq     <= 1'b0;
      r_ovf     <= 1'b0;
      r_lost    <= 8'd0;
    end else if (clr) begin
      r_prev    <= w_flags;
      r_pending <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ff      <= 8'd0;
      r_ffv     <= 1'b0;
      r_irq     <= 1'b0;
      r_ovf     <= 1'b0;
      r_lost    <= 8'd0;
    end else begin
      r_prev    <= w_flags;
      r_pending <= w_pend_nxt;
      r_wptr    <= w_push ? r_wptr + 1'b1 : r_wptr;
      r_rptr    <= w_pop  ? r_rptr + 1'b1 : r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_push && !r_ffv) begin
        r_ff  <= w_word;
        r_ffv <= 1'b1;
      end else begin
        r_ff  <= r_ff;
        r_ffv <= r_ffv;
      end
      r_irq  <= r_ffv;
      r_ovf  <= r_ovf | (|w_lose);
      r_lost <= w_lost_nxt;
    end
  end

  assign evt_valid         = (r_count != '0);
  assign evt_data          = evt_valid ? r_mem[r_rptr] : 8'd0;
  assign evt_count         = r_count;
  assign first_fault       = r_ff;
  assign first_fault_valid = r_ffv;
  assign irq               = r_irq;
  assign evt_overflow      = r_ovf;
  assign lost_count        = r_lost;

endmodule

// File: tb/tb_shim_hw_sts_evt_fifo.sv
// Randomized bench for shim_hw_sts_evt_fifo: a queue-based reference model is
// advanced every clock and all outputs are compared one time step after the edge.
module tb_shim_hw_sts_evt_fifo;

  localparam int D  = 16;
  localparam int NF = 106;

  logic         aclk = 1'b0;
  logic         areset;
  logic         clr;
  logic         evt_ready;
  logic [105:0] flags;
  logic [1:0]   sys_flags;
  logic [103:0] ch_flags;
  logic         evt_valid;
  logic [7:0]   evt_data;
  logic [4:0]   evt_count;
  logic [7:0]   first_fault;
  logic         first_fault_valid;
  logic         irq;
  logic         evt_overflow;
  logic [7:0]   lost_count;

  always #5 aclk = ~aclk;

  assign sys_flags = flags[1:0];
  assign ch_flags  = flags[105:2];

  shim_hw_sts_evt_fifo #(.FIFO_DEPTH(D)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .sys_flags         (sys_flags),
    .ch_flags          (ch_flags),
    .clr               (clr),
    .evt_ready         (evt_ready),
    .evt_valid         (evt_valid),
    .evt_data          (evt_data),
    .evt_count         (evt_count),
    .first_fault       (first_fault),
    .first_fault_valid (first_fault_valid),
    .irq               (irq),
    .evt_overflow      (evt_overflow),
    .lost_count        (lost_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [105:0] m_prev;
  logic [105:0] m_pend;
  logic [7:0]   m_q[$];
  logic [7:0]   m_ff;
  logic         m_ffv;
  logic         m_irq;
  logic         m_ovf;
  int           m_lost;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input int i);
    int code;
    int ch;
    if (i < 2) begin
      code = i + 1;
      ch   = 0;
    end else begin
      code = (i - 2) / 8 + 3;
      ch   = (i - 2) % 8;
    end
    return 8'(code * 8 + ch);
  endfunction

  task automatic model_step();
    bit pop;
    bit push;
    int idx;
    bit old_ffv;
    if (areset) begin
      m_pend = '0;
      m_q.delete();
      m_ff   = 8'd0;
      m_ffv  = 1'b0;
      m_irq  = 1'b0;
      m_ovf  = 1'b0;
      m_lost = 0;
      m_prev = '0;
    end else begin
      old_ffv = m_ffv;
      pop = (m_q.size() > 0) && evt_ready;
      idx = -1;
      for (int i = 0; i < NF; i++) begin
        if (m_pend[i] && idx < 0) idx = i;
      end
      push = (idx >= 0) && ((m_q.size() < D) || pop);
      if (clr) begin
        m_pend = '0;
        m_q.delete();
        m_ff   = 8'd0;
        m_ffv  = 1'b0;
        m_irq  = 1'b0;
        m_ovf  = 1'b0;
        m_lost = 0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back(enc(idx));
          m_pend[idx] = 1'b0;
          if (!m_ffv) begin
            m_ff  = enc(idx);
            m_ffv = 1'b1;
          end
        end
        for (int i = 0; i < NF; i++) begin
          if (flags[i] && !m_prev[i]) begin
            if (m_pend[i]) begin
              if (m_lost < 255) m_lost++;
              m_ovf = 1'b1;
            end
            m_pend[i] = 1'b1;
          end
        end
        m_irq = old_ffv;
      end
      m_prev = flags;
    end
  endtask

  task automatic check_all();
    check_val("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    check_val("evt_data", 32'(evt_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check_val("evt_count", 32'(evt_count), 32'(m_q.size()));
    check_val("first_fault", 32'(first_fault), 32'(m_ff));
    check_val("first_fault_valid", 32'(first_fault_valid), 32'(m_ffv));
    check_val("irq", 32'(irq), 32'(m_irq));
    check_val("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
    check_val("lost_count", 32'(lost_count), 32'(m_lost));
  endtask

  task automatic cyc();
    @(posedge aclk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    areset = 1'b1; clr = 1'b0; evt_ready = 1'b0;
    flags = '0; flags[12] = 1'b1;
    m_prev = '0; m_pend = '0; m_ff = 8'd0; m_ffv = 1'b0;
    m_irq = 1'b0; m_ovf = 1'b0; m_lost = 0;
    cyc(); cyc();
    check_val("rst_count", 32'(evt_count), 32'd0);

    // Flag high across reset release is reported two cycles later
    areset = 1'b0;
    cyc(); cyc();
    check_val("t1_data", 32'(evt_data), 32'h22);
    check_val("t1_ff", 32'(first_fault), 32'h22);
    cyc();
    check_val("t1_irq", 32'(irq), 32'd1);
    check_val("t1_count", 32'(evt_count), 32'd1);

    // Simultaneous edges come out in ascending index order
    pulse_clr();
    flags[1] = 1'b1; flags[2] = 1'b1;
    cyc(); cyc();
    check_val("t2_head", 32'(evt_data), 32'h10);
    cyc();
    check_val("t2_count", 32'(evt_count), 32'd2);
    check_val("t2_ff", 32'(first_fault), 32'h10);
    evt_ready = 1'b1;
    cyc();
    check_val("t2_second", 32'(evt_data), 32'h18);
    repeat (3) cyc();
    flags = '0;
    cyc();

    // Twenty edges into a sixteen-deep FIFO, then drain
    pulse_clr();
    evt_ready = 1'b0;
    for (int i = 30; i < 50; i++) flags[i] = 1'b1;
    repeat (25) cyc();
    check_val("t3_full", 32'(evt_count), 32'd16);
    check_val("t3_lost", 32'(lost_count), 32'd0);
    evt_ready = 1'b1;
    repeat (25) cyc();
    check_val("t3_empty", 32'(evt_count), 32'd0);

    // Coalescing while full, including saturation
    flags = '0;
    pulse_clr();
    evt_ready = 1'b0;
    for (int i = 60; i < 76; i++) flags[i] = 1'b1;
    repeat (20) cyc();
    flags[5] = 1'b1;
    cyc(); cyc();
    for (int k = 0; k < 3; k++) begin
      flags[5] = 1'b0; cyc();
      flags[5] = 1'b1; cyc();
    end
    check_val("t4_lost3", 32'(lost_count), 32'd3);
    check_val("t4_ovf", 32'(evt_overflow), 32'd1);
    for (int k = 0; k < 297; k++) begin
      flags[5] = 1'b0; cyc();
      flags[5] = 1'b1; cyc();
    end
    check_val("t4_sat", 32'(lost_count), 32'd255);
    evt_ready = 1'b1;
    repeat (20) cyc();

    // clr with words queued and a flag held high
    flags = '0;
    pulse_clr();
    evt_ready = 1'b0;
    for (int i = 80; i < 85; i++) flags[i] = 1'b1;
    repeat (8) cyc();
    check_val("t5_pre", 32'(evt_count), 32'd5);
    pulse_clr();
    check_val("t5_count", 32'(evt_count), 32'd0);
    check_val("t5_ffv", 32'(first_fault_valid), 32'd0);
    cyc();
    check_val("t5_irq", 32'(irq), 32'd0);
    repeat (3) cyc();
    check_val("t5_held", 32'(evt_count), 32'd0);
    flags[80] = 1'b0; cyc();
    flags[80] = 1'b1; cyc(); cyc();
    check_val("t5_rearm", 32'(evt_data), 32'(enc(80)));

    // Reset mid-drain, held flags reported again after release
    for (int i = 90; i < 96; i++) flags[i] = 1'b1;
    repeat (10) cyc();
    evt_ready = 1'b1;
    cyc();
    areset = 1'b1; cyc();
    check_val("t6_rst_valid", 32'(evt_valid), 32'd0);
    areset = 1'b0;
    cyc(); cyc();
    check_val("t6_rerep", 32'(evt_data), 32'(enc(80)));

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      int nt;
      nt = int'($urandom_range(0, 2));
      for (int t = 0; t < nt; t++) begin
        int b;
        b = int'($urandom_range(0, NF - 1));
        flags[b] = ~flags[b];
      end
      if ((c / 60) % 3 == 1) evt_ready = 1'b0;
      else evt_ready = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 120) == 0);
      areset = ($urandom_range(0, 250) == 0);
      cyc();
    end
    clr = 1'b0; areset = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
